// File: rtl/spm_dma_pkg.sv
// Shared types and bus encodings for the scratchpad-memory DMA initiator.
package spm_dma_pkg;

    // Bus widths of the surrounding codebase
    localparam int SPM_ADDR_W    = 12;
    localparam int WORD_DATA_W   = 32;
    localparam int SPM_DMA_LEN_W = 13;

    // Active-low strobe levels
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    // Read/write select levels
    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    typedef logic [SPM_ADDR_W-1:0]    spm_addr_bus_t;
    typedef logic [WORD_DATA_W-1:0]   word_data_bus_t;
    typedef logic [SPM_DMA_LEN_W-1:0] spm_dma_len_bus_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'h0,
        ST_RD   = 2'h1,
        ST_WR   = 2'h2,
        ST_DONE = 2'h3
    } spm_dma_state_e;

    typedef enum logic {
        MODE_COPY = 1'b0,
        MODE_FILL = 1'b1
    } spm_dma_mode_e;

endpackage

// File: rtl/spm_dma.sv
// Scratchpad DMA initiator: block copy or constant fill over SPM port B,
// advancing only on cycles where the MEM-stage arbiter grants the port.
module spm_dma
    import spm_dma_pkg::*;
#(
    parameter int ADDR_W = SPM_ADDR_W,
    parameter int DATA_W = WORD_DATA_W,
    parameter int LEN_W  = SPM_DMA_LEN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              abort,
    input  logic              spm_gnt,
    output logic [ADDR_W-1:0] spm_addr,
    output logic              spm_as_,
    output logic              spm_rw,
    output logic [DATA_W-1:0] spm_wr_data,
    input  logic [DATA_W-1:0] spm_rd_data,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);

    spm_dma_state_e    state_q;
    spm_dma_mode_e     mode_q;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [LEN_W-1:0]  rem_q;
    logic [DATA_W-1:0] fill_q;
    logic [DATA_W-1:0] data_q;
    logic              cap_q;
    logic              last_wr;

    // The final granted write wins over a simultaneous abort
    assign last_wr = (state_q == ST_WR) && spm_gnt && (rem_q == LEN_ONE);

    // Transfer sequencer with registered busy/done/aborted flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_COPY;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            fill_q  <= '0;
            data_q  <= '0;
            cap_q   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            aborted <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        src_q   <= src_addr;
                        dst_q   <= dst_addr;
                        rem_q   <= len;
                        mode_q  <= spm_dma_mode_e'(mode);
                        fill_q  <= fill_data;
                        cap_q   <= 1'b0;
                        aborted <= 1'b0;
                        busy    <= 1'b1;
                        if (len == '0) begin
                            state_q <= ST_DONE;
                            done    <= 1'b1;
                        end else if (mode == MODE_FILL) begin
                            state_q <= ST_WR;
                        end else begin
                            state_q <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (spm_gnt) begin
                        state_q <= ST_WR;
                        cap_q   <= 1'b1;
                    end
                    if (abort) begin
                        state_q <= ST_DONE;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                    end
                end
                ST_WR: begin
                    // Read data is only valid for one cycle; keep it for stalled writes
                    if (cap_q) begin
                        data_q <= spm_rd_data;
                        cap_q  <= 1'b0;
                    end
                    if (spm_gnt) begin
                        src_q <= src_q + ADDR_ONE;
                        dst_q <= dst_q + ADDR_ONE;
                        rem_q <= rem_q - LEN_ONE;
                        if (rem_q == LEN_ONE) begin
                            state_q <= ST_DONE;
                            done    <= 1'b1;
                        end else if (mode_q == MODE_COPY) begin
                            state_q <= ST_RD;
                        end
                    end
                    if (abort && !last_wr) begin
                        state_q <= ST_DONE;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // SPM port drive; strobe follows the grant so reset drops it at once
    always_comb begin
        spm_as_     = DISABLE_;
        spm_rw      = READ;
        spm_addr    = '0;
        spm_wr_data = '0;
        case (state_q)
            ST_RD: begin
                spm_addr = src_q;
                spm_as_  = spm_gnt ? ENABLE_ : DISABLE_;
            end
            ST_WR: begin
                spm_addr = dst_q;
                spm_rw   = WRITE;
                spm_as_  = spm_gnt ? ENABLE_ : DISABLE_;
                if (mode_q == MODE_FILL) begin
                    spm_wr_data = fill_q;
                end else begin
                    spm_wr_data = cap_q ? spm_rd_data : data_q;
                end
            end
            default: begin
                spm_as_ = DISABLE_;
            end
        endcase
    end

endmodule

// File: tb/tb_spm_dma.sv
// Directed bench for spm_dma with a 1-cycle-latency SPM model.
module tb_spm_dma;
    import spm_dma_pkg::*;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int LW = 13;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          mode;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [LW-1:0] len;
    logic [DW-1:0] fill_data;
    logic          abort;
    logic          spm_gnt;
    logic [AW-1:0] spm_addr;
    logic          spm_as_;
    logic          spm_rw;
    logic [DW-1:0] spm_wr_data;
    logic [DW-1:0] spm_rd_data;
    logic          busy;
    logic          done;
    logic          aborted;

    int checks = 0;
    int errors = 0;

    spm_dma #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .fill_data(fill_data), .abort(abort), .spm_gnt(spm_gnt),
        .spm_addr(spm_addr), .spm_as_(spm_as_), .spm_rw(spm_rw),
        .spm_wr_data(spm_wr_data), .spm_rd_data(spm_rd_data),
        .busy(busy), .done(done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    // SPM model: 1-cycle read latency, garbage on rd_data when not reading
    logic [DW-1:0] mem [0:4095];
    logic [AW-1:0] wr_log [0:31];
    int            acc_cnt = 0;
    int            wr_cnt  = 0;
    logic [DW-1:0] garbage = 32'hBAD0_0000;
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    always @(posedge clk) begin
        garbage <= garbage + 32'd1;
        if (pl_en) mem[pl_addr] <= pl_data;
        if (spm_as_ == 1'b0 && spm_rw == READ) begin
            spm_rd_data <= mem[spm_addr];
        end else begin
            spm_rd_data <= garbage;
        end
        if (spm_as_ == 1'b0) begin
            acc_cnt <= acc_cnt + 1;
            if (spm_rw == WRITE) begin
                mem[spm_addr]       <= spm_wr_data;
                wr_log[wr_cnt[4:0]] <= spm_addr;
                wr_cnt              <= wr_cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    // Counts edges after the start-sampling edge until done is seen
    task automatic wait_done(input int budget, output int edges);
        edges = 0;
        while (done !== 1'b1 && edges < budget) begin
            @(negedge clk);
            edges++;
        end
    endtask

    initial begin
        int            e;
        int            w0;
        int            a0;
        int            a1;
        int            k;
        logic [AW-1:0] exp_a;

        reset = 1'b0; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
        len = '0; fill_data = '0; abort = 1'b0; spm_gnt = 1'b1;
        repeat (2) @(negedge clk);

        // Reset values
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_aborted", aborted, 1'b0);
        check("rst_as", spm_as_, DISABLE_);
        check("rst_rw", spm_rw, READ);
        check("rst_addr", spm_addr, 12'h000);
        check("rst_wdata", spm_wr_data, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // Abort while idle has no effect
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("idle_abort", {busy, aborted}, 2'b00);

        // Copy 4 words with constant grant
        for (int i = 0; i < 4; i++) preload(AW'(12'h010 + i), 32'hA0 + i);
        for (int i = 0; i < 4; i++) preload(AW'(12'h100 + i), 32'h0);
        preload(12'h104, 32'h55);
        w0 = wr_cnt;
        mode = 1'b0; src_addr = 12'h010; dst_addr = 12'h100; len = 13'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("copy_busy", busy, 1'b1);
        wait_done(40, e);
        check("copy_latency", e, 8);
        check("copy_busy_in_done", busy, 1'b1);
        @(negedge clk);
        check("copy_done_pulse", done, 1'b0);
        check("copy_busy_low", busy, 1'b0);
        for (int i = 0; i < 4; i++) check("copy_data", mem[12'h100 + i], 32'hA0 + i);
        check("copy_no_overrun", mem[12'h104], 32'h55);
        check("copy_wr_count", wr_cnt - w0, 4);

        // Fill across the top-of-memory wrap
        w0 = wr_cnt;
        mode = 1'b1; dst_addr = 12'hFFE; len = 13'd4; fill_data = 32'hDEADBEEF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(40, e);
        check("fill_latency", e, 4);
        @(negedge clk);
        check("fill_wr_count", wr_cnt - w0, 4);
        exp_a = 12'hFFE;
        for (int i = 0; i < 4; i++) begin
            check("fill_addr", wr_log[(w0 + i) % 32], exp_a);
            check("fill_data", mem[exp_a], 32'hDEADBEEF);
            exp_a = exp_a + 12'd1;
        end

        // Grant stall between read and write
        preload(12'h020, 32'h12345678);
        preload(12'h200, 32'h0);
        w0 = wr_cnt;
        mode = 1'b0; src_addr = 12'h020; dst_addr = 12'h200; len = 13'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("stall_read_strobe", {spm_as_, spm_rw}, {ENABLE_, READ});
        @(negedge clk);
        spm_gnt = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            check("stall_as_high", spm_as_, DISABLE_);
            check("stall_wdata", spm_wr_data, 32'h12345678);
            @(negedge clk);
        end
        check("stall_garbage_present", (spm_rd_data !== 32'h12345678), 1'b1);
        spm_gnt = 1'b1;
        @(negedge clk);
        wait_done(10, e);
        check("stall_done", e, 0);
        check("stall_data", mem[12'h200], 32'h12345678);
        check("stall_wr_count", wr_cnt - w0, 1);
        @(negedge clk);

        // Zero length
        a0 = acc_cnt;
        mode = 1'b0; len = 13'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(10, e);
        check("len0_latency", e, 0);
        @(negedge clk);
        check("len0_idle", {busy, done}, 2'b00);
        check("len0_no_access", acc_cnt - a0, 0);

        // Abort after the third write
        for (int i = 0; i < 8; i++) preload(AW'(12'h040 + i), 32'hC0 + i);
        for (int i = 0; i < 8; i++) preload(AW'(12'h300 + i), 32'h0);
        w0 = wr_cnt;
        mode = 1'b0; src_addr = 12'h040; dst_addr = 12'h300; len = 13'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (wr_cnt - w0 < 3 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("abort_reach_3", wr_cnt - w0, 3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_done", done, 1'b1);
        check("abort_flag", aborted, 1'b1);
        @(negedge clk);
        check("abort_idle", busy, 1'b0);
        check("abort_wr_count", wr_cnt - w0, 3);
        check("abort_third", mem[12'h302], 32'hC2);
        check("abort_fourth_untouched", mem[12'h303], 32'h0);
        len = 13'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_clears_aborted", aborted, 1'b0);
        @(negedge clk);

        // Abort coinciding with the last granted write completes normally
        w0 = wr_cnt;
        mode = 1'b1; dst_addr = 12'h500; len = 13'd2; fill_data = 32'h600D; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("last_abort_done", done, 1'b1);
        check("last_abort_flag", aborted, 1'b0);
        check("last_abort_wr_count", wr_cnt - w0, 2);
        check("last_abort_data", mem[12'h501], 32'h600D);
        @(negedge clk);

        // Asynchronous reset during a write cycle
        preload(12'h060, 32'h77);
        preload(12'h400, 32'h0);
        a0 = acc_cnt;
        mode = 1'b0; src_addr = 12'h060; dst_addr = 12'h400; len = 13'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("rst_mid_in_wr", {spm_as_, spm_rw}, {ENABLE_, WRITE});
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_as", spm_as_, DISABLE_);
        check("rst_mid_busy", busy, 1'b0);
        a1 = acc_cnt;
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_mid_only_read", a1 - a0, 1);
        check("rst_mid_no_access", acc_cnt - a1, 0);
        check("rst_mid_no_write", mem[12'h400], 32'h0);
        check("rst_mid_flags", {busy, done, aborted}, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
